// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program-driven order/data/w issuer for the lab CPU controller
module prog_sequencer #(
   parameter int DEPTH     = 16,
   parameter int TIMEOUT   = 8,
   parameter int SHOW_HOLD = 4,
   parameter int GAP_CYC   = 2,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          run_en,
   input  logic          step,
   input  logic          rewind,
   input  logic          ld_we,
   input  logic          ld_clr,
   input  logic [AW-1:0] ld_addr,
   input  logic [7:0]    ld_order,
   input  logic [7:0]    ld_data,
   input  logic          done_in,
   output logic [7:0]    order,
   output logic [7:0]    data,
   output logic          w,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic          err_timeout
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, GAP, HALT} state_t;

   localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

   state_t          state;
   logic [7:0]      mem_order [DEPTH];
   logic [7:0]      mem_data  [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [7:0]      cnt;
   logic            done_seen;
   logic            step_mode;
   logic            load_ok;
   logic            is_show;

   assign load_ok = (state == IDLE) || (state == HALT);
   assign is_show = (order[7:4] == 4'hF);

   // Program storage carries no reset; only the valid bits are cleared.
   always_ff @(posedge clk) begin
      if (ld_we && load_ok && !ld_clr) begin
         mem_order[ld_addr] <= ld_order;
         mem_data[ld_addr]  <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         order       <= '0;
         data        <= '0;
         w           <= 1'b0;
         pc          <= '0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         err_timeout <= 1'b0;
         valid       <= '0;
         cnt         <= '0;
         done_seen   <= 1'b0;
         step_mode   <= 1'b0;
      end else begin
         w <= 1'b0;
         if (ld_clr && load_ok)
            valid <= '0;
         else if (ld_we && load_ok)
            valid[ld_addr] <= 1'b1;

         case (state)
            IDLE: begin
               if (rewind) begin
                  pc          <= '0;
                  err_timeout <= 1'b0;
               end else if (run_en || step) begin
                  state     <= FETCH;
                  busy      <= 1'b1;
                  step_mode <= !run_en;
               end
            end
            FETCH: begin
               if (!valid[pc]) begin
                  state  <= HALT;
                  busy   <= 1'b0;
                  halted <= 1'b1;
               end else begin
                  order <= mem_order[pc];
                  data  <= mem_data[pc];
                  state <= ISSUE;
               end
            end
            // order has been on the bus for this whole cycle before w shows up.
            ISSUE: begin
               w         <= 1'b1;
               done_seen <= done_in;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               if (is_show ? (cnt == 8'(SHOW_HOLD - 1)) : (done_in || done_seen)) begin
                  if (pc == LAST_PC) begin
                     state  <= HALT;
                     busy   <= 1'b0;
                     halted <= 1'b1;
                  end else begin
                     pc    <= pc + 1'b1;
                     cnt   <= '0;
                     state <= GAP;
                  end
               end else if (!is_show && (cnt == 8'(TIMEOUT - 1))) begin
                  err_timeout <= 1'b1;
                  halted      <= 1'b1;
                  busy        <= 1'b0;
                  state       <= HALT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == 8'(GAP_CYC - 1)) begin
                  if (!step_mode && run_en) begin
                     state <= FETCH;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HALT: begin
               if (rewind) begin
                  state       <= IDLE;
                  halted      <= 1'b0;
                  err_timeout <= 1'b0;
                  pc          <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - randomized self-checking bench for prog_sequencer
module tb_prog_sequencer;
   localparam int DEPTH = 16, TIMEOUT = 8, SHOW_HOLD = 4;

   logic clk = 1'b0, rst = 1'b1;
   logic run_en = 0, step = 0, rewind = 0, ld_we = 0, ld_clr = 0, done_in = 0;
   logic [3:0] ld_addr = 0;
   logic [7:0] ld_order = 0, ld_data = 0;
   logic [7:0] order, data;
   logic w, busy, halted, err_timeout;
   logic [3:0] pc;

   prog_sequencer dut (
      .clk(clk), .rst(rst), .run_en(run_en), .step(step), .rewind(rewind),
      .ld_we(ld_we), .ld_clr(ld_clr), .ld_addr(ld_addr), .ld_order(ld_order),
      .ld_data(ld_data), .done_in(done_in), .order(order), .data(data), .w(w),
      .pc(pc), .busy(busy), .halted(halted), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int tests_run = 0, fails = 0;
   bit done_auto = 1'b0;

   // Program image as the bench believes it to be.
   logic [7:0] exp_o [DEPTH];
   logic [7:0] exp_d [DEPTH];
   bit         exp_v [DEPTH];

   // Observed w pulses.
   logic [7:0] rec_order [$];
   logic [7:0] rec_data  [$];
   logic [3:0] rec_pc    [$];
   int         viol = 0;
   logic [7:0] prev_order = 0;
   logic       prev_w = 0;

   initial forever begin
      @(posedge clk); #1;
      if (w === 1'b1) begin
         rec_order.push_back(order); rec_data.push_back(data); rec_pc.push_back(pc);
         if (prev_order !== order || prev_w === 1'b1) viol++;
      end
      prev_order = order; prev_w = w;
   end

   // Controller Done model: responds 0..4 cycles after w.
   initial forever begin
      @(posedge clk); #1;
      if (w === 1'b1 && done_auto) begin
         repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
         done_in = 1'b1;
         @(posedge clk); #1;
         done_in = 1'b0;
      end
   end

   task automatic tick(); @(posedge clk); #1; endtask

   task automatic clear_rec();
      rec_order.delete(); rec_data.delete(); rec_pc.delete(); viol = 0;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [7:0] o, input logic [7:0] d);
      ld_we = 1; ld_addr = a; ld_order = o; ld_data = d; tick(); ld_we = 0;
      exp_o[a] = o; exp_d[a] = d; exp_v[a] = 1;
   endtask

   task automatic clear_prog();
      ld_clr = 1; tick(); ld_clr = 0;
      for (int i = 0; i < DEPTH; i++) exp_v[i] = 0;
   endtask

   task automatic do_rewind(); rewind = 1; tick(); rewind = 0; tick(); endtask

   task automatic wait_for_w(input string tag);
      int n = 0;
      while (w !== 1'b1 && n < 40) begin tick(); n++; end
      tests_run++;
      if (w !== 1'b1) begin fails++; $display("FAIL %s: w never rose (got %b, want 1)", tag, w); end
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 100) begin tick(); n++; end
      tests_run++;
      if (busy !== 1'b0) begin fails++; $display("FAIL %s: busy stuck (got %b, want 0)", tag, busy); end
   endtask

   task automatic wait_halt(input string tag);
      int n = 0;
      while (halted !== 1'b1 && n < 600) begin tick(); n++; end
      tests_run++;
      if (halted !== 1'b1) begin fails++; $display("FAIL %s: halted never set (got %b, want 1)", tag, halted); end
   endtask

   // Model: a run from pc 0 issues the valid prefix of the program, in order.
   task automatic check_run(input string tag, input int exp_n, input logic [3:0] exp_pc);
      tests_run++;
      if (rec_order.size() != exp_n) begin fails++; $display("FAIL %s pulses: got %0d want %0d", tag, rec_order.size(), exp_n); end
      for (int i = 0; i < exp_n && i < rec_order.size(); i++) begin
         tests_run++;
         if (rec_order[i] !== exp_o[i] || rec_data[i] !== exp_d[i] || rec_pc[i] !== 4'(i)) begin
            fails++;
            $display("FAIL %s word %0d: got %h/%h pc%0d want %h/%h pc%0d", tag, i,
                     rec_order[i], rec_data[i], rec_pc[i], exp_o[i], exp_d[i], i);
         end
      end
      tests_run++;
      if (pc !== exp_pc || halted !== 1'b1 || err_timeout !== 1'b0 || viol != 0) begin
         fails++;
         $display("FAIL %s end: pc=%0d halted=%b err=%b viol=%0d want pc=%0d halted=1 err=0 viol=0",
                  tag, pc, halted, err_timeout, viol, exp_pc);
      end
   endtask

   function automatic int valid_prefix();
      int n = 0;
      while (n < DEPTH && exp_v[n]) n++;
      return n;
   endfunction

   task automatic test_reset();
      tests_run++;
      if ({order, data, w, pc, busy, halted, err_timeout} !== '0) begin
         fails++; $display("FAIL reset_init: got %h/%h w%b pc%0d b%b h%b e%b want all 0", order, data, w, pc, busy, halted, err_timeout);
      end
      load_word(0, 8'h12, 8'h34);
      done_auto = 0;
      step = 1; tick(); step = 0;
      wait_for_w("reset_w");
      tick(); tick();
      rst = 1; #1;
      tests_run++;
      if ({order, data, w, pc, busy, halted, err_timeout} !== '0) begin
         fails++; $display("FAIL reset_mid_wait: got %h/%h w%b pc%0d b%b h%b e%b want all 0", order, data, w, pc, busy, halted, err_timeout);
      end
      for (int i = 0; i < DEPTH; i++) exp_v[i] = 0;
      tick(); rst = 0; tick();
      clear_rec();
      run_en = 1; tick();
      wait_halt("reset_refetch");
      run_en = 0;
      tests_run++;
      if (pc !== 4'd0 || rec_order.size() != 0 || err_timeout !== 1'b0) begin
         fails++; $display("FAIL reset_refetch: pc=%0d pulses=%0d err=%b want 0/0/0", pc, rec_order.size(), err_timeout);
      end
      do_rewind();
   endtask

   task automatic test_run();
      load_word(0, 8'b0000_0000, 8'h02);
      load_word(1, 8'b0000_0100, 8'h05);
      load_word(2, 8'b0001_0010, 8'($urandom));
      load_word(3, 8'b0010_0001, 8'($urandom));
      load_word(4, 8'b1111_0011, 8'($urandom));
      done_auto = 1; clear_rec();
      run_en = 1; tick();
      wait_halt("run");
      run_en = 0;
      check_run("run", valid_prefix(), 4'd5);
   endtask

   task automatic test_step();
      do_rewind(); clear_rec();
      for (int i = 0; i < 3; i++) begin
         step = 1; tick(); step = 0;
         tick(); step = 1; tick(); step = 0;
         wait_idle("step");
         tests_run++;
         if (pc !== 4'(i + 1) || halted !== 1'b0 || rec_order.size() != i + 1) begin
            fails++; $display("FAIL step %0d: pc=%0d halted=%b pulses=%0d want %0d/0/%0d", i, pc, halted, rec_order.size(), i + 1, i + 1);
         end
      end
      repeat (6) tick();
      tests_run++;
      if (rec_order.size() != 3 || busy !== 1'b0 || viol != 0) begin
         fails++; $display("FAIL step_settle: pulses=%0d busy=%b viol=%0d want 3/0/0", rec_order.size(), busy, viol);
      end
   endtask

   task automatic test_timeout();
      do_rewind(); clear_prog();
      load_word(0, 8'b0001_0110, 8'($urandom));
      done_auto = 0;
      step = 1; tick(); step = 0;
      wait_for_w("timeout_w");
      repeat (TIMEOUT - 1) tick();
      tests_run++;
      if (err_timeout !== 1'b0 || halted !== 1'b0) begin
         fails++; $display("FAIL timeout_early: err=%b halted=%b want 0/0", err_timeout, halted);
      end
      tick();
      tests_run++;
      if (err_timeout !== 1'b1 || halted !== 1'b1 || pc !== 4'd0 || busy !== 1'b0) begin
         fails++; $display("FAIL timeout_hit: err=%b halted=%b pc=%0d busy=%b want 1/1/0/0", err_timeout, halted, pc, busy);
      end
      rewind = 1; tick(); rewind = 0;
      tests_run++;
      if (err_timeout !== 1'b0 || halted !== 1'b0 || pc !== 4'd0) begin
         fails++; $display("FAIL timeout_rewind: err=%b halted=%b pc=%0d want 0/0/0", err_timeout, halted, pc);
      end
   endtask

   task automatic test_show();
      clear_prog();
      load_word(0, 8'b1111_0110, 8'($urandom));
      done_auto = 0;
      step = 1; tick(); step = 0;
      wait_for_w("show_w");
      repeat (SHOW_HOLD - 1) tick();
      tests_run++;
      if (pc !== 4'd0) begin fails++; $display("FAIL show_early: pc=%0d want 0", pc); end
      tick();
      tests_run++;
      if (pc !== 4'd1 || busy !== 1'b1 || err_timeout !== 1'b0) begin
         fails++; $display("FAIL show_gap: pc=%0d busy=%b err=%b want 1/1/0", pc, busy, err_timeout);
      end
      wait_idle("show_idle");
      tests_run++;
      if (halted !== 1'b0 || err_timeout !== 1'b0) begin
         fails++; $display("FAIL show_done: halted=%b err=%b want 0/0", halted, err_timeout);
      end
   endtask

   task automatic test_load_and_start();
      logic [7:0] o;
      do_rewind(); clear_rec();
      ld_we = 1; ld_clr = 1; ld_addr = 0; ld_order = 8'h55; tick(); ld_we = 0; ld_clr = 0;
      for (int i = 0; i < DEPTH; i++) exp_v[i] = 0;
      step = 1; tick(); step = 0;
      wait_halt("clr_beats_we");
      tests_run++;
      if (pc !== 4'd0 || rec_order.size() != 0) begin
         fails++; $display("FAIL clr_beats_we: pc=%0d pulses=%0d want 0/0", pc, rec_order.size());
      end
      do_rewind();
      done_auto = 1;
      o = 8'($urandom_range(0, 8'hEF));
      ld_we = 1; ld_addr = 0; ld_order = o; ld_data = 8'hA5; step = 1;
      tick(); ld_we = 0; step = 0;
      wait_idle("ld_start");
      tests_run++;
      if (rec_order.size() != 1 || rec_order[0] !== o || rec_data[0] !== 8'hA5 || pc !== 4'd1) begin
         fails++; $display("FAIL ld_start: pulses=%0d order=%h pc=%0d want 1/%h/1", rec_order.size(),
                           (rec_order.size() > 0) ? rec_order[0] : 8'hxx, pc, o);
      end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_rewind(); clear_prog();
      for (int i = 0; i < DEPTH; i++) load_word(4'(i), 8'($urandom), 8'($urandom));
      done_auto = 1; clear_rec();
      run_en = 1; tick();
      while (rec_order.size() < 3 && n < 200) begin tick(); n++; end
      ld_we = 1; ld_addr = 4'd15; ld_order = ~exp_o[15]; ld_data = ~exp_d[15]; tick(); ld_we = 0;
      wait_halt("eom");
      run_en = 0;
      check_run("eom", DEPTH, 4'd15);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) exp_v[i] = 0;
      tick(); tick();
      rst = 0; tick();
      test_reset();
      test_run();
      test_step();
      test_timeout();
      test_show();
      test_load_and_start();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
